wb_arbiter: RTL and testbench

Shares the single general-register write port among three writeback requesters: ALU (0), LSU load return (1) and MDU multi-cycle mul/div (2). It uses a round-robin valid/ready handshake.
It also holds a per-register busy scoreboard for long-latency destinations, so the decode stage can stall RAW/WAW hazards.
Sits between the EX/LSU/MDU result paths and the register file write port; the scoreboard read side faces decode.

---
 rtl/wb_arbiter_pkg.sv | 24 ++
 rtl/wb_arbiter_if.sv | 46 ++++
 rtl/wb_arbiter_rr_arbiter3.sv | 54 +++++
 rtl/wb_arbiter.sv | 79 +++++++
 tb/tb_wb_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter: register bus widths,
// requester indices and the zero/enable constants used across the block.
package wb_arbiter_pkg;

    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int NumReq  = 3;

    typedef logic [ADDR_W-1:0] RegAddrBus;
    typedef logic [DATA_W-1:0] RegDataBus;

    localparam int        RegNum   = REG_NUM;
    localparam RegAddrBus ZeroReg  = '0;
    localparam RegDataBus ZeroWord = '0;
    localparam logic      Enable   = 1'b1;

    typedef enum logic [1:0] {
        ReqAlu = 2'd0,
        ReqLsu = 2'd1,
        ReqMdu = 2'd2
    } req_idx_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback requester, register-file write port and scoreboard signals of
// wb_arbiter, grouped into one bundle with arbiter (slave) and environment (master) views.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic      I_req0_valid, I_req1_valid, I_req2_valid;
    RegAddrBus I_req0_rd,    I_req1_rd,    I_req2_rd;
    RegDataBus I_req0_data,  I_req1_data,  I_req2_data;
    logic      O_req0_ready, O_req1_ready, O_req2_ready;

    logic      O_rd_we;
    RegAddrBus O_rd_waddr;
    RegDataBus O_rd_wdata;

    logic      I_alloc_valid;
    RegAddrBus I_alloc_rd;
    logic      O_alloc_ready;

    RegAddrBus I_rs1_raddr, I_rs2_raddr;
    logic      O_rs1_busy,  O_rs2_busy;

    modport slave (
        input  I_req0_valid, I_req1_valid, I_req2_valid,
        input  I_req0_rd, I_req1_rd, I_req2_rd,
        input  I_req0_data, I_req1_data, I_req2_data,
        output O_req0_ready, O_req1_ready, O_req2_ready,
        output O_rd_we, O_rd_waddr, O_rd_wdata,
        input  I_alloc_valid, I_alloc_rd,
        output O_alloc_ready,
        input  I_rs1_raddr, I_rs2_raddr,
        output O_rs1_busy, O_rs2_busy
    );

    modport master (
        output I_req0_valid, I_req1_valid, I_req2_valid,
        output I_req0_rd, I_req1_rd, I_req2_rd,
        output I_req0_data, I_req1_data, I_req2_data,
        input  O_req0_ready, O_req1_ready, O_req2_ready,
        input  O_rd_we, O_rd_waddr, O_rd_wdata,
        output I_alloc_valid, I_alloc_rd,
        input  O_alloc_ready,
        output I_rs1_raddr, I_rs2_raddr,
        input  O_rs1_busy, O_rs2_busy
    );

endinterface

// File: rtl/wb_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter: zero-latency one-hot grant, search starts at
// ptr_q; after a grant to r the pointer moves to r+1 (mod 3).
module rr_arbiter3
    import wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o
);

    logic [1:0] ptr_q, ptr_d;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if chain can leave it unassigned and infer a latch.
    always_comb begin
        gnt_o = '0;
        case (ptr_q)
            2'd1: begin
                if      (req_i[1]) gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
            end
            2'd2: begin
                if      (req_i[2]) gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
            end
            default: begin
                if      (req_i[0]) gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
            end
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        case (gnt_o)
            3'b001:  ptr_d = 2'd1;
            3'b010:  ptr_d = 2'd2;
            3'b100:  ptr_d = 2'd0;
            default: ptr_d = ptr_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 2'd0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback port arbiter for ALU/LSU/MDU results plus the busy scoreboard that
// lets decode stall on pending long-latency destinations.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    logic [NumReq-1:0] req, gnt;
    RegAddrBus         waddr;
    RegDataBus         wdata;
    logic              clr_en;
    logic              alloc_ok;
    logic [RegNum-1:0] busy_q, busy_d;

    // Requests are masked during reset so nothing is granted or written.
    assign req = {bus.I_req2_valid, bus.I_req1_valid, bus.I_req0_valid} & {NumReq{~rst}};

    rr_arbiter3 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign bus.O_req0_ready = gnt[ReqAlu];
    assign bus.O_req1_ready = gnt[ReqLsu];
    assign bus.O_req2_ready = gnt[ReqMdu];

    always_comb begin
        waddr = ZeroReg;
        wdata = ZeroWord;
        if (gnt[ReqAlu]) begin
            waddr = bus.I_req0_rd;
            wdata = bus.I_req0_data;
        end else if (gnt[ReqLsu]) begin
            waddr = bus.I_req1_rd;
            wdata = bus.I_req1_data;
        end else if (gnt[ReqMdu]) begin
            waddr = bus.I_req2_rd;
            wdata = bus.I_req2_data;
        end
    end

    assign bus.O_rd_we    = (|gnt) && (waddr != ZeroReg);
    assign bus.O_rd_waddr = waddr;
    assign bus.O_rd_wdata = wdata;

    // Only long-latency returns retire a busy bit; ALU writes leave it alone.
    assign clr_en   = (gnt[ReqLsu] || gnt[ReqMdu]) && (waddr != ZeroReg);
    assign alloc_ok = !rst && bus.I_alloc_valid && !busy_q[bus.I_alloc_rd];

    assign bus.O_alloc_ready = alloc_ok;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[waddr] = 1'b0;
        if (alloc_ok && (bus.I_alloc_rd != ZeroReg)) busy_d[bus.I_alloc_rd] = Enable;
        busy_d[0] = 1'b0;
    end

    // NOTE: the busy vector is a plain flop array, so it is cleared by reset
    // like any other state; it is not a RAM and costs nothing to reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // Bypass mirrors the register file's same-cycle forwarding of the write.
    assign bus.O_rs1_busy = (bus.I_rs1_raddr != ZeroReg) && busy_q[bus.I_rs1_raddr]
                            && !(clr_en && (waddr == bus.I_rs1_raddr));
    assign bus.O_rs2_busy = (bus.I_rs2_raddr != ZeroReg) && busy_q[bus.I_rs2_raddr]
                            && !(clr_en && (waddr == bus.I_rs2_raddr));

    a_clear_pending: assert property (@(posedge clk) disable iff (rst) clr_en |-> busy_q[waddr]);

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios then randomized traffic,
// each cycle's expected outputs queued by the driver and compared by a monitor.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0]  ready;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        alloc_ready;
        logic        rs1_busy;
        logic        rs2_busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   mon_cyc = 0;

    // Requester/decode stimulus state
    bit          cur_v[3];
    logic [4:0]  cur_rd[3];
    logic [31:0] cur_data[3];
    logic        a_v;
    logic [4:0]  a_rd, rs1, rs2;
    bit          hold_valid = 0;
    bit          rand_mode  = 0;

    // Reference model: pointer as an integer, busy set as a bit array
    int          ptr = 0;
    bit          busy[32];
    logic [4:0]  pend_lsu[$];
    logic [4:0]  pend_mdu[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, mon_cyc, act, req);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("ready",       {bus.O_req2_ready, bus.O_req1_ready, bus.O_req0_ready}, mon_e.ready);
            check("rd_we",       bus.O_rd_we,       mon_e.we);
            check("rd_waddr",    bus.O_rd_waddr,    mon_e.waddr);
            check("rd_wdata",    bus.O_rd_wdata,    mon_e.wdata);
            check("alloc_ready", bus.O_alloc_ready, mon_e.alloc_ready);
            check("rs1_busy",    bus.O_rs1_busy,    mon_e.rs1_busy);
            check("rs2_busy",    bus.O_rs2_busy,    mon_e.rs2_busy);
            mon_cyc++;
        end
    end

    // One clock: drive inputs, predict outputs, advance the model at the edge.
    task automatic cycle();
        exp_t       e;
        int         g = -1;
        bit         clr;
        logic [4:0] clr_rd = '0;

        bus.I_req0_valid = cur_v[0]; bus.I_req0_rd = cur_rd[0]; bus.I_req0_data = cur_data[0];
        bus.I_req1_valid = cur_v[1]; bus.I_req1_rd = cur_rd[1]; bus.I_req1_data = cur_data[1];
        bus.I_req2_valid = cur_v[2]; bus.I_req2_rd = cur_rd[2]; bus.I_req2_data = cur_data[2];
        bus.I_alloc_valid = a_v;
        bus.I_alloc_rd    = a_rd;
        bus.I_rs1_raddr   = rs1;
        bus.I_rs2_raddr   = rs2;

        e.ready = '0; e.we = 0; e.waddr = '0; e.wdata = '0;
        e.alloc_ready = 0; e.rs1_busy = 0; e.rs2_busy = 0;
        clr = 0;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                int r = (ptr + k) % 3;
                if (g < 0 && cur_v[r]) g = r;
            end
            if (g >= 0) begin
                e.ready[g] = 1'b1;
                e.waddr    = cur_rd[g];
                e.wdata    = cur_data[g];
                e.we       = (cur_rd[g] != 0);
                clr        = (g > 0) && (cur_rd[g] != 0);
                clr_rd     = cur_rd[g];
            end
            e.alloc_ready = a_v && !busy[a_rd];
            e.rs1_busy    = (rs1 != 0) && busy[rs1] && !(clr && clr_rd == rs1);
            e.rs2_busy    = (rs2 != 0) && busy[rs2] && !(clr && clr_rd == rs2);
        end
        exp_q.push_back(e);

        @(posedge clk);
        if (rst) begin
            ptr = 0;
            foreach (busy[i]) busy[i] = 0;
        end else begin
            if (g >= 0) begin
                ptr = (g + 1) % 3;
                if (clr) busy[clr_rd] = 0;
                if (!hold_valid) cur_v[g] = 0;
                if (rand_mode && g == 1 && pend_lsu.size() > 0) void'(pend_lsu.pop_front());
                if (rand_mode && g == 2 && pend_mdu.size() > 0) void'(pend_mdu.pop_front());
            end
            if (e.alloc_ready && a_rd != 0) begin
                busy[a_rd] = 1;
                if (rand_mode) begin
                    if ($urandom % 2 == 0) pend_lsu.push_back(a_rd);
                    else                   pend_mdu.push_back(a_rd);
                end
            end
        end
        #1;
    endtask

    task automatic set_req(input int r, input logic [4:0] rd, input logic [31:0] data);
        cur_v[r] = 1; cur_rd[r] = rd; cur_data[r] = data;
    endtask

    initial begin
        foreach (cur_v[i]) begin cur_v[i] = 0; cur_rd[i] = '0; cur_data[i] = '0; end
        a_v = 0; a_rd = '0; rs1 = '0; rs2 = '0;
        rst = 1;
        @(posedge clk); #1;

        // Reset state
        cycle(); cycle();
        rst = 0;

        // Round robin, all three continuously valid; allocs keep 6/7 pending
        a_v = 1; a_rd = 5'd6; cycle();
        a_rd = 5'd7; cycle();
        hold_valid = 1;
        set_req(0, 5'd5, 32'h11); set_req(1, 5'd6, 32'h22); set_req(2, 5'd7, 32'h33);
        for (int k = 0; k < 9; k++) begin
            a_rd = (k % 2 == 0) ? 5'd6 : 5'd7;
            cycle();
        end
        a_v = 0;
        cycle();

        // Reset in the middle of a would-be grant, all requesters valid
        rst = 1; cycle(); cycle();
        rst = 0;
        hold_valid = 0;
        a_v = 1; a_rd = 5'd6; cycle();
        a_rd = 5'd7; cycle();
        a_v = 0; cycle();

        // x0 write
        set_req(0, 5'd0, 32'hDEADBEEF); cycle();

        // Scoreboard lifecycle on rd 10
        a_v = 1; a_rd = 5'd10; rs1 = 5'd10; cycle();
        cycle();
        a_v = 0; set_req(2, 5'd10, 32'h1234); cycle();
        cycle();

        // Collision: clear of rd 3 and alloc of rd 3 in the same cycle
        a_v = 1; a_rd = 5'd3; rs1 = 5'd3; cycle();
        set_req(1, 5'd3, 32'hCAFE0003); cycle();
        cycle();
        a_v = 0; cycle();
        pend_lsu.push_back(5'd3);

        // ALU write to a busy rd does not clear it
        a_v = 1; a_rd = 5'd8; cycle();
        a_v = 0; set_req(0, 5'd8, 32'h55); rs2 = 5'd8; cycle();
        cycle();
        pend_mdu.push_back(5'd8);

        // Randomized traffic
        rand_mode = 1;
        for (int n = 0; n < 3000; n++) begin
            if (!cur_v[0] && $urandom % 2 == 0) set_req(0, 5'($urandom), $urandom);
            if (!cur_v[1] && pend_lsu.size() > 0 && $urandom % 3 == 0) set_req(1, pend_lsu[0], $urandom);
            if (!cur_v[2] && pend_mdu.size() > 0 && $urandom % 3 == 0) set_req(2, pend_mdu[0], $urandom);
            a_v  = ($urandom % 2 == 0);
            a_rd = 5'($urandom % 16);
            rs1  = 5'($urandom % 16);
            rs2  = ($urandom % 4 == 0) ? rs1 : 5'($urandom % 16);
            cycle();
        end

        @(negedge clk); #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
